omp_x_loader: RTL and testbench
===============================

// Module: omp_x_loader
// PURPOSE
//  Upstream feeder for the OMP X-vector block RAM. Accepts a valid/ready word
//  stream, writes each accepted word to consecutive RAM addresses from 0 via
//  the RAM's single write port (addr0/ce0/we0/d0), then pulses done so the
//  OMP core may start reading X. Detects short, long and oversize frames.
// PARAMETERS
//  DWIDTH    32   data word width; matches the RAM word
//  AWIDTH    8    RAM address width
//  MEM_SIZE  256  RAM depth in words; must be <= 2**AWIDTH
// PORTS
//  clk       in   1         single clock, rising edge
//  rst_n     in   1         asynchronous reset, active low
//  start     in   1         load request, sampled only in IDLE
//  cfg_len   in   AWIDTH+1  words to load, sampled with start
//  s_data    in   DWIDTH    stream word
//  s_valid   in   1         stream word valid
//  s_last    in   1         marks final stream word
//  s_ready   out  1         loader accepts word; transfer = s_valid & s_ready
//  ram_addr0 out  AWIDTH    RAM address
//  ram_ce0   out  1         RAM enable
//  ram_we0   out  1         RAM write enable
//  ram_d0    out  DWIDTH    RAM write data
//  busy      out  1         high in any state except IDLE
//  done      out  1         one-cycle pulse at end of load
//  err_short out  1         s_last came before cfg_len words; sticky to next start
//  err_long  out  1         word cfg_len lacked s_last; sticky to next start
//  err_len   out  1         cfg_len==0 or cfg_len>MEM_SIZE; sticky to next start
// BEHAVIOUR
//  - Reset: all outputs 0; state=IDLE; word counter cnt=0.
//  - States: IDLE, LOAD, FILL (only with macro), FIN.
//  - IDLE: s_ready=0. On start, latch len=cfg_len, clear all err flags, cnt=0.
//    If len==0 or len>MEM_SIZE: set err_len, go to FIN with no RAM writes.
//    Otherwise go to LOAD.
//  - LOAD: s_ready=1. Each transfer registers ram_ce0=ram_we0=1,
//    ram_addr0=cnt[AWIDTH-1:0], ram_d0=s_data on the next edge, so the strobe
//    is high the cycle after the transfer. Then cnt++. Strobes are 0 in cycles
//    with no transfer. Throughput is 1 word/cycle. No stall comes from the RAM.
//  - End of LOAD, on the transfer of word number cnt+1:
//    * ==len with s_last=1: go to FIN.
//    * ==len with s_last=0: set err_long, go to FIN. Extra words are not
//      accepted, because s_ready stays 0 until the next start.
//    * <len with s_last=1: set err_short, go to FIN, or to FILL with the macro.
//  - FIN: s_ready=0, busy=1 for one cycle. The last write strobe is in this
//    cycle. done pulses on the next cycle, with state=IDLE and busy=0.
//  - start while busy: ignored. s_valid while not in LOAD: ignored.
//  - Counter: AWIDTH+1 bits. The address never wraps, because len<=MEM_SIZE.
//  - Reset mid-load: immediate abort. Strobes drop asynchronously. RAM
//    contents are left undefined. No done pulse.
// CONFIGURATION
//  OMP_X_LOADER_ZFILL_EN
//  - Defined: a short frame enters FILL. s_ready=0. Writes d0=0 at addresses
//    cnt..len-1, one per cycle, then goes to FIN. err_short is still set.
//  - Undefined: FILL does not exist. A short frame goes straight to FIN and
//    RAM words cnt..MEM_SIZE-1 keep their stale values.
// TESTING
//  - len=4, words A0..A3 back-to-back, s_last on A3 -> writes addr 0..3 on
//    consecutive cycles; done 2 cycles after A3 accepted; no err flags.
//  - len=4, s_valid toggled 1,0,1,0... -> 4 writes with gaps; addresses 0..3
//    in order; done pulse; s_ready=0 after 4th word.
//  - len=5, s_last on 3rd word -> err_short=1; done. With ZFILL_EN: addr 3,4
//    written with 0 before done. Without: exactly 3 writes.
//  - len=3, no s_last on 3rd word -> err_long=1; s_ready=0; a 4th word stays
//    unaccepted; done pulses.
//  - len=0, then len=257 (MEM_SIZE=256) -> err_len=1; ram_ce0 never high;
//    done 2 cycles after start. len=256 full frame -> last address 255.
//  - rst_n low after 2 of 8 words -> outputs 0 immediately; new start with
//    len=2 loads from addr 0 normally.

Source files
------------

// File: rtl/omp_x_loader.sv
// Stream-to-RAM loader for the OMP X vector: writes accepted words to addresses 0..len-1, then pulses done.
// Optional zero-fill of short frames is compiled in with `define OMP_X_LOADER_ZFILL_EN.
module omp_x_loader #(
  parameter int DWIDTH   = 32,
  parameter int AWIDTH   = 8,
  parameter int MEM_SIZE = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [AWIDTH:0]   cfg_len,
  input  logic [DWIDTH-1:0] s_data,
  input  logic              s_valid,
  input  logic              s_last,
  output logic              s_ready,
  output logic [AWIDTH-1:0] ram_addr0,
  output logic              ram_ce0,
  output logic              ram_we0,
  output logic [DWIDTH-1:0] ram_d0,
  output logic              busy,
  output logic              done,
  output logic              err_short,
  output logic              err_long,
  output logic              err_len
);

  localparam logic [AWIDTH:0] MAX_LEN = (AWIDTH+1)'(MEM_SIZE);
  localparam logic [AWIDTH:0] ONE     = {{AWIDTH{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
`ifdef OMP_X_LOADER_ZFILL_EN
    FILL = 2'd2,
`endif
    FIN  = 2'd3
  } state_t;

  state_t          state;
  logic [AWIDTH:0] cnt;
  logic [AWIDTH:0] len;
  logic [AWIDTH:0] cnt_inc;

  assign cnt_inc = cnt + ONE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      len       <= '0;
      s_ready   <= 1'b0;
      ram_addr0 <= '0;
      ram_ce0   <= 1'b0;
      ram_we0   <= 1'b0;
      ram_d0    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err_short <= 1'b0;
      err_long  <= 1'b0;
      err_len   <= 1'b0;
    end else begin
      ram_ce0 <= 1'b0;
      ram_we0 <= 1'b0;
      done    <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            len       <= cfg_len;
            cnt       <= '0;
            busy      <= 1'b1;
            err_short <= 1'b0;
            err_long  <= 1'b0;
            if (cfg_len == '0 || cfg_len > MAX_LEN) begin
              err_len <= 1'b1;
              state   <= FIN;
            end else begin
              err_len <= 1'b0;
              s_ready <= 1'b1;
              state   <= LOAD;
            end
          end
        end
        LOAD: begin
          if (s_valid && s_ready) begin
            ram_ce0   <= 1'b1;
            ram_we0   <= 1'b1;
            ram_addr0 <= cnt[AWIDTH-1:0];
            ram_d0    <= s_data;
            cnt       <= cnt_inc;
            // A full-length frame wins over s_last: the missing marker is the error.
            if (cnt_inc == len) begin
              err_long <= ~s_last;
              s_ready  <= 1'b0;
              state    <= FIN;
            end else if (s_last) begin
              err_short <= 1'b1;
              s_ready   <= 1'b0;
`ifdef OMP_X_LOADER_ZFILL_EN
              state     <= FILL;
`else
              state     <= FIN;
`endif
            end
          end
        end
`ifdef OMP_X_LOADER_ZFILL_EN
        FILL: begin
          ram_ce0   <= 1'b1;
          ram_we0   <= 1'b1;
          ram_addr0 <= cnt[AWIDTH-1:0];
          ram_d0    <= '0;
          cnt       <= cnt_inc;
          if (cnt_inc == len) state <= FIN;
        end
`endif
        FIN: begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_omp_x_loader.sv
// Bench for omp_x_loader: directed vector table, reset corner cases and random frames vs a frame-level model.
module tb_omp_x_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [8:0]  cfg_len = '0;
  logic [31:0] s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_last = 1'b0;
  logic        s_ready;
  logic [7:0]  ram_addr0;
  logic        ram_ce0, ram_we0;
  logic [31:0] ram_d0;
  logic        busy, done, err_short, err_long, err_len;

  omp_x_loader #(.DWIDTH(32), .AWIDTH(8), .MEM_SIZE(256)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_len(cfg_len),
    .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
    .ram_addr0(ram_addr0), .ram_ce0(ram_ce0), .ram_we0(ram_we0), .ram_d0(ram_d0),
    .busy(busy), .done(done), .err_short(err_short), .err_long(err_long), .err_len(err_len)
  );

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;

  task automatic chk(input string name, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  int          nc = 0;
  int          done_cnt = 0, done_nc = 0;
  int          acc_cnt = 0, acc_nc = 0, start_nc = 0, we_bad = 0;
  int          wa_q[$];
  logic [31:0] wd_q[$];
  int          wn_q[$];

  always @(negedge clk) begin
    nc++;
    if (rst_n) begin
      if (ram_ce0) begin
        wa_q.push_back(int'(ram_addr0));
        wd_q.push_back(ram_d0);
        wn_q.push_back(nc);
        if (!ram_we0) we_bad++;
      end
      if (done) begin done_cnt++; done_nc = nc; end
      if (s_valid && s_ready) begin acc_cnt++; acc_nc = nc; end
      if (start && !busy) start_nc = nc;
    end
  end

  // Frame-level reference model.
  logic [31:0] words[$];
  int          m_a[$];
  logic [31:0] m_d[$];
  bit          m_es, m_el, m_en;
  int          m_cons, m_fill;

  task automatic model(input int len, input int nw, input int lastp);
    m_a.delete(); m_d.delete();
    m_es = 0; m_el = 0; m_en = 0; m_cons = 0; m_fill = 0;
    if (len == 0 || len > 256) m_en = 1;
    else begin
      for (int i = 0; i < nw; i++) begin
        m_a.push_back(i); m_d.push_back(words[i]); m_cons = i + 1;
        if (i + 1 == len) begin m_el = (i != lastp); break; end
        if (i == lastp) begin
          m_es = 1;
`ifdef OMP_X_LOADER_ZFILL_EN
          for (int a = i + 1; a < len; a++) begin
            m_a.push_back(a); m_d.push_back(32'h0); m_fill++;
          end
`endif
          break;
        end
      end
    end
  endtask

  // Drives one frame, waits for done, and checks it against the model.
  task automatic run_frame(input string tag, input int len, input int nw, input int lastp, input int vmode);
    int  i = 0;
    int  c = 0;
    bit  xfer;
    int  n;
    words.delete();
    for (int k = 0; k < nw; k++) words.push_back($urandom);
    model(len, nw, lastp);
    wa_q.delete(); wd_q.delete(); wn_q.delete();
    done_cnt = 0; acc_cnt = 0; we_bad = 0;
    start = 1'b1; cfg_len = 9'(len);
    @(posedge clk); #1;
    start = 1'b0;
    while (done_cnt == 0 && c < 3000) begin
      if (i < nw) begin
        case (vmode)
          0: s_valid = 1'b1;
          1: s_valid = (c % 2 == 0);
          default: s_valid = 1'($urandom_range(0, 1));
        endcase
        s_data = words[i];
        s_last = (i == lastp);
      end else begin
        s_valid = 1'b0; s_last = 1'b0;
      end
      xfer = s_valid && s_ready;
      @(posedge clk); #1;
      if (xfer) i++;
      c++;
    end
    s_valid = 1'b0; s_last = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk({tag, " done_pulses"}, done_cnt, 1);
    chk({tag, " err_short"}, err_short, m_es);
    chk({tag, " err_long"}, err_long, m_el);
    chk({tag, " err_len"}, err_len, m_en);
    chk({tag, " busy_idle"}, busy, 0);
    chk({tag, " s_ready_idle"}, s_ready, 0);
    chk({tag, " accepted"}, acc_cnt, m_cons);
    chk({tag, " we_with_ce"}, we_bad, 0);
    chk({tag, " write_count"}, wa_q.size(), m_a.size());
    n = (wa_q.size() < m_a.size()) ? wa_q.size() : m_a.size();
    for (int k = 0; k < n; k++) begin
      chk($sformatf("%s addr[%0d]", tag, k), wa_q[k], m_a[k]);
      chk($sformatf("%s data[%0d]", tag, k), wd_q[k], m_d[k]);
    end
    if (m_en) chk({tag, " done_after_start"}, done_nc - start_nc, 2);
    else      chk({tag, " done_after_last"}, done_nc - acc_nc, 2 + m_fill);
    if (vmode == 0 && !m_en && wn_q.size() > 0)
      chk({tag, " back_to_back"}, wn_q[wn_q.size()-1] - wn_q[0], wn_q.size() - 1);
  endtask

  typedef struct {
    int len; int nw; int lastp; int vmode;
    bit e_s; bit e_l; bit e_n; int nwr_nofill; int nwr_fill;
  } vec_t;

  vec_t tv[9];

  initial begin
    tv[0] = '{4, 4, 3, 0, 1'b0, 1'b0, 1'b0, 4, 4};
    tv[1] = '{4, 4, 3, 1, 1'b0, 1'b0, 1'b0, 4, 4};
    tv[2] = '{5, 3, 2, 0, 1'b1, 1'b0, 1'b0, 3, 5};
    tv[3] = '{3, 4, -1, 0, 1'b0, 1'b1, 1'b0, 3, 3};
    tv[4] = '{0, 2, 1, 0, 1'b0, 1'b0, 1'b1, 0, 0};
    tv[5] = '{257, 2, 1, 0, 1'b0, 1'b0, 1'b1, 0, 0};
    tv[6] = '{256, 256, 255, 0, 1'b0, 1'b0, 1'b0, 256, 256};
    tv[7] = '{1, 1, 0, 1, 1'b0, 1'b0, 1'b0, 1, 1};
    tv[8] = '{2, 2, 0, 2, 1'b1, 1'b0, 1'b0, 1, 2};

    #12;
    chk("reset_outputs", {s_ready, ram_addr0, ram_ce0, ram_we0, ram_d0, busy, done,
                          err_short, err_long, err_len}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int t = 0; t < 9; t++) begin
      string tag;
      tag = $sformatf("vec%0d", t);
      run_frame(tag, tv[t].len, tv[t].nw, tv[t].lastp, tv[t].vmode);
      chk({tag, " tbl_err_short"}, err_short, tv[t].e_s);
      chk({tag, " tbl_err_long"}, err_long, tv[t].e_l);
      chk({tag, " tbl_err_len"}, err_len, tv[t].e_n);
`ifdef OMP_X_LOADER_ZFILL_EN
      chk({tag, " tbl_writes"}, wa_q.size(), tv[t].nwr_fill);
`else
      chk({tag, " tbl_writes"}, wa_q.size(), tv[t].nwr_nofill);
`endif
      if (tv[t].len == 256) chk({tag, " last_addr"}, wa_q[wa_q.size()-1], 255);
    end

    // Reset in the middle of an 8-word frame, then a clean 2-word load.
    begin
      int c = 0;
      acc_cnt = 0;
      start = 1'b1; cfg_len = 9'd8;
      @(posedge clk); #1;
      start = 1'b0;
      s_valid = 1'b1; s_data = 32'hA5A5_0000; s_last = 1'b0;
      while (acc_cnt < 2 && c < 50) begin
        @(posedge clk); #1;
        s_data = s_data + 32'd1;
        c++;
      end
      s_valid = 1'b0;
      chk("midload_accepted", acc_cnt, 2);
      chk("midload_strobe_before_rst", ram_ce0, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midload_outputs_cleared", {s_ready, ram_addr0, ram_ce0, ram_we0, ram_d0, busy, done,
                                      err_short, err_long, err_len}, 0);
      done_cnt = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("midload_no_done", done_cnt, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      run_frame("after_rst", 2, 2, 1, 0);
    end

    // Random frames, mostly well-formed lengths with occasional invalid ones.
    for (int r = 0; r < 24; r++) begin
      int len, lastp, nw, sel;
      sel = $urandom_range(0, 9);
      if (sel == 0) len = 0;
      else if (sel == 1) len = $urandom_range(257, 511);
      else len = $urandom_range(1, 24);
      lastp = int'($urandom_range(0, 26)) - 1;
      nw = ((len > lastp + 1) ? len : lastp + 1) + 1;
      if (nw > 300) nw = 300;
      run_frame($sformatf("rnd%0d", r), len, nw, lastp, $urandom_range(0, 2));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
